// File: rtl/cs151_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cs151_pkg
// Brief    : Shared types and encodings for the CS151 multi-cycle controller.
// Revision : 1.0 - initial release
// ============================================================================
package cs151_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_addi  = 6'h08;
    localparam logic [5:0] c_op_lw    = 6'h23;
    localparam logic [5:0] c_op_sw    = 6'h2B;
    localparam logic [5:0] c_op_beq   = 6'h04;

    localparam logic [5:0] c_fn_add   = 6'h20;
    localparam logic [5:0] c_fn_sub   = 6'h22;
    localparam logic [5:0] c_fn_and   = 6'h24;
    localparam logic [5:0] c_fn_or    = 6'h25;
    localparam logic [5:0] c_fn_slt   = 6'h2A;

    localparam logic [3:0] c_aluop_and = 4'b0000;
    localparam logic [3:0] c_aluop_or  = 4'b0001;
    localparam logic [3:0] c_aluop_add = 4'b0010;
    localparam logic [3:0] c_aluop_sub = 4'b0110;
    localparam logic [3:0] c_aluop_slt = 4'b0111;

    localparam logic [1:0] c_cause_none     = 2'b00;
    localparam logic [1:0] c_cause_illegal  = 2'b01;
    localparam logic [1:0] c_cause_fetch_to = 2'b10;
    localparam logic [1:0] c_cause_data_to  = 2'b11;

endpackage
`default_nettype wire

// File: rtl/cs151_inst_decode.sv
`default_nettype none
// ============================================================================
// Module   : cs151_inst_decode
// Brief    : Combinational opcode/funct decode into ALU controls and class flags.
// Revision : 1.0 - initial release
// ============================================================================
module cs151_inst_decode
    import cs151_pkg::*;
#(
    parameter int INST_W  = 32,
    parameter int ALUOP_W = 4
) (
    input  logic [INST_W-1:0]  i_inst,
    output logic [ALUOP_W-1:0] o_aluop,
    output logic               o_alusrc,
    output logic               o_is_load,
    output logic               o_is_store,
    output logic               o_is_branch,
    output logic               o_is_rtype_wb,
    output logic               o_illegal
);

    logic [5:0] w_opcode;
    logic [5:0] w_funct;
    logic [3:0] w_code;
    logic       w_unused;

    assign w_opcode = i_inst[INST_W-1 -: 6];
    assign w_funct  = i_inst[5:0];
    assign w_unused = ^i_inst[INST_W-7:6];

    always_comb begin
        w_code        = c_aluop_and;
        o_alusrc      = 1'b0;
        o_is_load     = 1'b0;
        o_is_store    = 1'b0;
        o_is_branch   = 1'b0;
        o_is_rtype_wb = 1'b0;
        o_illegal     = 1'b0;
        case (w_opcode)
            c_op_rtype: begin
                o_is_rtype_wb = 1'b1;
                case (w_funct)
                    c_fn_add: w_code = c_aluop_add;
                    c_fn_sub: w_code = c_aluop_sub;
                    c_fn_and: w_code = c_aluop_and;
                    c_fn_or:  w_code = c_aluop_or;
                    c_fn_slt: w_code = c_aluop_slt;
                    default: begin
                        o_is_rtype_wb = 1'b0;
                        o_illegal     = 1'b1;
                    end
                endcase
            end
            c_op_addi: begin
                w_code        = c_aluop_add;
                o_alusrc      = 1'b1;
                o_is_rtype_wb = 1'b1;
            end
            c_op_lw: begin
                w_code    = c_aluop_add;
                o_alusrc  = 1'b1;
                o_is_load = 1'b1;
            end
            c_op_sw: begin
                w_code     = c_aluop_add;
                o_alusrc   = 1'b1;
                o_is_store = 1'b1;
            end
            c_op_beq: begin
                w_code      = c_aluop_sub;
                o_is_branch = 1'b1;
            end
            default: o_illegal = 1'b1;
        endcase
    end

    assign o_aluop = ALUOP_W'(w_code);

endmodule
`default_nettype wire

// File: rtl/cs151_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : cs151_multicycle_controller
// Brief    : FETCH/DECODE/EXEC/MEM/WB sequencer with memory timeout trap.
// Revision : 1.0 - initial release
// ============================================================================
module cs151_multicycle_controller
    import cs151_pkg::*;
#(
    parameter int INST_W      = 32,
    parameter int ALUOP_W     = 4,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INST_W-1:0]  inst,
    input  logic               mem_ack,
    input  logic               alu_zero,
    output logic [ALUOP_W-1:0] ALUopsel,
    output logic               MUXsel1,
    output logic               Regwrite,
    output logic               ir_load,
    output logic               pc_load,
    output logic               pc_branch,
    output logic               mem_req,
    output logic               mem_we,
    output logic               trap,
    output logic [1:0]         trap_cause,
    output logic [CNT_W-1:0]   retired
);

    localparam int                  c_tcnt_w = $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_tcnt_w-1:0] c_tlimit = c_tcnt_w'(MEM_TIMEOUT - 1);

    state_t              r_state;
    logic [ALUOP_W-1:0]  r_aluop;
    logic                r_alusrc;
    logic                r_regwrite;
    logic                r_mem_req;
    logic                r_mem_we;
    logic                r_trap;
    logic [1:0]          r_cause;
    logic [CNT_W-1:0]    r_retired;
    logic [c_tcnt_w-1:0] r_tcnt;
    logic                r_is_load;
    logic                r_is_store;
    logic                r_is_branch;
    logic                r_is_rtype_wb;

    logic [ALUOP_W-1:0]  w_aluop;
    logic                w_alusrc;
    logic                w_is_load;
    logic                w_is_store;
    logic                w_is_branch;
    logic                w_is_rtype_wb;
    logic                w_illegal;
    logic                w_fetch_ack;
    logic                w_exec_branch;

    cs151_inst_decode #(
        .INST_W  (INST_W),
        .ALUOP_W (ALUOP_W)
    ) u_decode (
        .i_inst        (inst),
        .o_aluop       (w_aluop),
        .o_alusrc      (w_alusrc),
        .o_is_load     (w_is_load),
        .o_is_store    (w_is_store),
        .o_is_branch   (w_is_branch),
        .o_is_rtype_wb (w_is_rtype_wb),
        .o_illegal     (w_illegal)
    );

    // IR/PC strobes must coincide with the ack / zero flag of the same cycle.
    assign w_fetch_ack   = (r_state == ST_FETCH) && r_mem_req && mem_ack;
    assign w_exec_branch = (r_state == ST_EXEC) && r_is_branch;

    assign ir_load    = w_fetch_ack;
    assign pc_load    = w_fetch_ack | w_exec_branch;
    assign pc_branch  = w_exec_branch & alu_zero;
    assign ALUopsel   = r_aluop;
    assign MUXsel1    = r_alusrc;
    assign Regwrite   = r_regwrite;
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign trap       = r_trap;
    assign trap_cause = r_cause;
    assign retired    = r_retired;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_FETCH;
            r_aluop       <= '0;
            r_alusrc      <= 1'b0;
            r_regwrite    <= 1'b0;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_trap        <= 1'b0;
            r_cause       <= c_cause_none;
            r_retired     <= '0;
            r_tcnt        <= '0;
            r_is_load     <= 1'b0;
            r_is_store    <= 1'b0;
            r_is_branch   <= 1'b0;
            r_is_rtype_wb <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    // First cycle after reset launches the request.
                    if (!r_mem_req) begin
                        r_mem_req <= 1'b1;
                        r_tcnt    <= '0;
                    end else if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_state   <= ST_DECODE;
                    end else if (r_tcnt == c_tlimit) begin
                        r_mem_req <= 1'b0;
                        r_trap    <= 1'b1;
                        r_cause   <= c_cause_fetch_to;
                        r_state   <= ST_TRAP;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                ST_DECODE: begin
                    if (w_illegal) begin
                        r_trap  <= 1'b1;
                        r_cause <= c_cause_illegal;
                        r_state <= ST_TRAP;
                    end else begin
                        r_aluop       <= w_aluop;
                        r_alusrc      <= w_alusrc;
                        r_is_load     <= w_is_load;
                        r_is_store    <= w_is_store;
                        r_is_branch   <= w_is_branch;
                        r_is_rtype_wb <= w_is_rtype_wb;
                        r_state       <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (r_is_branch) begin
                        r_retired <= r_retired + 1'b1;
                        r_state   <= ST_FETCH;
                        r_mem_req <= 1'b1;
                        r_tcnt    <= '0;
                        r_aluop   <= '0;
                        r_alusrc  <= 1'b0;
                    end else if (r_is_load || r_is_store) begin
                        r_state   <= ST_MEM;
                        r_mem_req <= 1'b1;
                        r_mem_we  <= r_is_store;
                        r_tcnt    <= '0;
                    end else if (r_is_rtype_wb) begin
                        r_regwrite <= 1'b1;
                        r_state    <= ST_WB;
                    end else begin
                        r_trap   <= 1'b1;
                        r_cause  <= c_cause_illegal;
                        r_aluop  <= '0;
                        r_alusrc <= 1'b0;
                        r_state  <= ST_TRAP;
                    end
                end
                ST_MEM: begin
                    if (mem_ack) begin
                        r_mem_we <= 1'b0;
                        if (r_is_load) begin
                            r_mem_req  <= 1'b0;
                            r_regwrite <= 1'b1;
                            r_state    <= ST_WB;
                        end else begin
                            r_retired <= r_retired + 1'b1;
                            r_state   <= ST_FETCH;
                            r_tcnt    <= '0;
                            r_aluop   <= '0;
                            r_alusrc  <= 1'b0;
                        end
                    end else if (r_tcnt == c_tlimit) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_aluop   <= '0;
                        r_alusrc  <= 1'b0;
                        r_trap    <= 1'b1;
                        r_cause   <= c_cause_data_to;
                        r_state   <= ST_TRAP;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                ST_WB: begin
                    r_regwrite <= 1'b0;
                    r_retired  <= r_retired + 1'b1;
                    r_state    <= ST_FETCH;
                    r_mem_req  <= 1'b1;
                    r_tcnt     <= '0;
                    r_aluop    <= '0;
                    r_alusrc   <= 1'b0;
                end
                ST_TRAP: r_state <= ST_TRAP;
                default: r_state <= ST_FETCH;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cs151_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_cs151_multicycle_controller
// Brief    : Randomized self-checking bench against an instruction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cs151_multicycle_controller;

    localparam int INST_W      = 32;
    localparam int ALUOP_W     = 4;
    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 4;

    localparam int K_ALU = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_ILL = 4;

    typedef struct {
        int         kind;
        logic [3:0] aluop;
        logic       src;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [INST_W-1:0]  inst = '0;
    logic               mem_ack = 1'b0;
    logic               alu_zero = 1'b0;
    logic [ALUOP_W-1:0] ALUopsel;
    logic               MUXsel1, Regwrite, ir_load, pc_load, pc_branch;
    logic               mem_req, mem_we, trap;
    logic [1:0]         trap_cause;
    logic [CNT_W-1:0]   retired;

    int n_checks = 0;
    int n_errors = 0;
    int m_retired = 0;

    cs151_multicycle_controller #(
        .INST_W(INST_W), .ALUOP_W(ALUOP_W), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .inst(inst), .mem_ack(mem_ack), .alu_zero(alu_zero),
        .ALUopsel(ALUopsel), .MUXsel1(MUXsel1), .Regwrite(Regwrite), .ir_load(ir_load),
        .pc_load(pc_load), .pc_branch(pc_branch), .mem_req(mem_req), .mem_we(mem_we),
        .trap(trap), .trap_cause(trap_cause), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input int k, input logic [3:0] a, input logic s);
        exp_t e;
        e.kind = k; e.aluop = a; e.src = s;
        return e;
    endfunction

    // Instruction-class table straight from the ISA definition.
    function automatic exp_t ref_decode(input logic [31:0] ins);
        logic [5:0] op, fn;
        op = ins[31:26];
        fn = ins[5:0];
        case (op)
            6'h00: case (fn)
                6'h20:   return mk(K_ALU, 4'b0010, 1'b0);
                6'h22:   return mk(K_ALU, 4'b0110, 1'b0);
                6'h24:   return mk(K_ALU, 4'b0000, 1'b0);
                6'h25:   return mk(K_ALU, 4'b0001, 1'b0);
                6'h2A:   return mk(K_ALU, 4'b0111, 1'b0);
                default: return mk(K_ILL, 4'b0000, 1'b0);
            endcase
            6'h08:   return mk(K_ALU, 4'b0010, 1'b1);
            6'h23:   return mk(K_LW,  4'b0010, 1'b1);
            6'h2B:   return mk(K_SW,  4'b0010, 1'b1);
            6'h04:   return mk(K_BEQ, 4'b0110, 1'b0);
            default: return mk(K_ILL, 4'b0000, 1'b0);
        endcase
    endfunction

    function automatic logic [31:0] rand_legal();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 8))
            0: begin r[31:26] = 6'h00; r[5:0] = 6'h20; end
            1: begin r[31:26] = 6'h00; r[5:0] = 6'h22; end
            2: begin r[31:26] = 6'h00; r[5:0] = 6'h24; end
            3: begin r[31:26] = 6'h00; r[5:0] = 6'h25; end
            4: begin r[31:26] = 6'h00; r[5:0] = 6'h2A; end
            5: r[31:26] = 6'h08;
            6: r[31:26] = 6'h23;
            7: r[31:26] = 6'h2B;
            default: r[31:26] = 6'h04;
        endcase
        return r;
    endfunction

    // Runs one instruction: fetch ack after df idle request cycles, data ack after dm.
    task automatic run_inst(input logic [31:0] ins, input int df, input int dm, input logic z);
        exp_t e;
        int   reqcnt, after, n_after, rw, il, memreq;
        logic fetched, we_seen, pcl, pcb, done;
        e = ref_decode(ins);
        reqcnt = 0; after = 0; rw = 0; il = 0; memreq = 0;
        fetched = 0; we_seen = 0; pcl = 0; pcb = 0; done = 0;
        case (e.kind)
            K_ALU:   n_after = 3;
            K_BEQ:   n_after = 2;
            K_SW:    n_after = 3 + dm;
            K_LW:    n_after = 4 + dm;
            default: n_after = 1;
        endcase
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            inst = ins; alu_zero = z; mem_ack = 1'b0;
            if (mem_req) begin
                reqcnt++;
                if (reqcnt == (fetched ? dm : df) + 1) mem_ack = 1'b1;
            end
            #1;
            if (c == 0) begin
                check("retired_before", 32'(retired), 32'(m_retired));
                check("trap_clear", 32'(trap), 0);
            end
            if (fetched) after++;
            if (Regwrite) rw++;
            if (ir_load) il++;
            if (fetched && mem_req) begin memreq++; we_seen |= mem_we; end
            if (after == 1) check("aluop_decode", 32'(ALUopsel), 0);
            if (after == 2 && e.kind != K_ILL) begin
                check("aluop_exec", 32'(ALUopsel), 32'(e.aluop));
                check("muxsel_exec", 32'(MUXsel1), 32'(e.src));
                pcl = pc_load; pcb = pc_branch;
            end
            if (after == n_after && (e.kind == K_ALU || e.kind == K_LW))
                check("aluop_wb_hold", 32'(ALUopsel), 32'(e.aluop));
            if (mem_ack && !fetched) begin fetched = 1'b1; reqcnt = 0; end
            if (fetched && after == n_after) done = 1'b1;
        end
        if (!done) check("inst_budget", 0, 1);
        check("ir_load_count", il, 1);
        check("regwrite_count", rw, (e.kind == K_ALU || e.kind == K_LW) ? 1 : 0);
        check("mem_req_cycles", memreq, (e.kind == K_LW || e.kind == K_SW) ? dm + 1 : 0);
        check("mem_we", 32'(we_seen), (e.kind == K_SW) ? 1 : 0);
        check("pc_load_exec", 32'(pcl), (e.kind == K_BEQ) ? 1 : 0);
        check("pc_branch", 32'(pcb), (e.kind == K_BEQ && z) ? 1 : 0);
        if (e.kind != K_ILL) m_retired = (m_retired + 1) % (1 << CNT_W);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        #1;
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_regwrite", 32'(Regwrite), 0);
        check("rst_aluop", 32'(ALUopsel), 0);
        check("rst_muxsel", 32'(MUXsel1), 0);
        check("rst_trap", 32'(trap), 0);
        check("rst_cause", 32'(trap_cause), 0);
        check("rst_retired", 32'(retired), 0);
        rst_n = 1'b1;
        m_retired = 0;
    endtask

    task automatic run_illegal(input logic [31:0] ins);
        run_inst(ins, 0, 0, 1'b0);
        repeat (4) begin
            @(negedge clk);
            mem_ack = 1'b1;
            #1;
            check("ill_trap", 32'(trap), 1);
            check("ill_cause", 32'(trap_cause), 1);
            check("ill_no_req", 32'(mem_req), 0);
            check("ill_no_ir", 32'(ir_load), 0);
            check("ill_aluop", 32'(ALUopsel), 0);
        end
        mem_ack = 1'b0;
        check("ill_retired_frozen", 32'(retired), 32'(m_retired));
    endtask

    task automatic run_timeout(input logic [31:0] ins, input logic in_mem);
        int   reqs;
        logic fetched, trapped;
        reqs = 0; fetched = 0; trapped = 0;
        for (int c = 0; c < 100 && !trapped; c++) begin
            @(negedge clk);
            inst = ins; mem_ack = 1'b0;
            if (in_mem && !fetched && mem_req) mem_ack = 1'b1;
            #1;
            if (trap) trapped = 1'b1;
            else if (mem_req && !mem_ack) reqs++;
            if (mem_ack) fetched = 1'b1;
        end
        mem_ack = 1'b0;
        check("to_trap", 32'(trapped), 1);
        check("to_cycles", reqs, MEM_TIMEOUT);
        check("to_cause", 32'(trap_cause), in_mem ? 3 : 2);
        check("to_mem_req", 32'(mem_req), 0);
        check("to_retired", 32'(retired), 32'(m_retired));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ins;
        do_reset();

        run_inst(32'h0000_0020, 0, 0, 1'b0);   // add
        run_inst(32'h8C00_0000, 0, 3, 1'b0);   // lw, data ack delayed 3
        run_inst(32'hAC00_0000, 0, 1, 1'b0);   // sw
        run_inst(32'h1000_0000, 0, 0, 1'b1);   // beq taken
        run_inst(32'h1000_0000, 2, 0, 1'b0);   // beq not taken
        run_inst(32'h2000_1234, 1, 0, 1'b0);   // addi
        run_inst(32'h0000_0020, MEM_TIMEOUT - 1, 0, 1'b0);
        run_inst(32'h8C00_0000, 0, MEM_TIMEOUT - 1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ins = rand_legal();
            run_inst(ins, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        // Reset while the data request is pending.
        @(negedge clk);
        inst = 32'h8C00_0000; mem_ack = mem_req;
        repeat (3) begin @(negedge clk); mem_ack = 1'b0; end
        #1;
        check("mem_wait_req", 32'(mem_req), 1);
        @(negedge clk);
        rst_n = 1'b0; mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        check("midrst_mem_req", 32'(mem_req), 0);
        check("midrst_retired", 32'(retired), 0);
        check("midrst_regwrite", 32'(Regwrite), 0);
        rst_n = 1'b1;
        m_retired = 0;
        run_inst(32'h0000_0022, 0, 0, 1'b0);

        run_illegal(32'hFC00_0000);
        do_reset();
        run_inst(32'h0000_002A, 0, 0, 1'b0);
        run_illegal(32'h0000_0021);
        do_reset();
        run_timeout(32'h0000_0020, 1'b0);
        do_reset();
        run_timeout(32'h8C00_0000, 1'b1);
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
